env_pwm_dac: RTL and testbench
==============================

ENV_PWM_DAC -- requirements
Module: env_pwm_dac

Interface
REQ-001 Parameter: PWM_BITS, default 10, PWM resolution; PWM period = 2^PWM_BITS clk cycles; legal range 4..16.
REQ-002 Port: clk  input  1  single system clock; all state on rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: enable  input  1  PWM run enable.
REQ-005 Port: sample  input  16  signed Q1.15 waveform sample.
REQ-006 Port: sample_valid  input  1  one-cycle strobe qualifying sample.
REQ-007 Port: env  input  16  unsigned Q0.16 envelope gain from the ADSR stage, 0xFFFF ~ 1.0.
REQ-008 Port: sample_tick  output  1  one-cycle pulse requesting the next sample, once per PWM period.
REQ-009 Port: pwm_out  output  1  registered PWM DAC output.
REQ-010 Port: level  output  16  signed, most recent scaled sample (debug/readback).

Function
REQ-011 Capture stage: on a clk edge with sample_valid=1, sample and env SHALL be registered together; no capture when sample_valid=0.
REQ-012 Scale stage: on the edge after a capture, level SHALL load (captured sample * zero-extended captured env), 33-bit signed product, arithmetic-shifted right 16 (floor), bits [15:0].
REQ-013 Duty conversion: pending_duty SHALL load on the same edge as level, = top PWM_BITS bits of (scaled + 0x8000) taken as unsigned 16-bit (offset binary).
REQ-014 Latency: sample_valid sampled at edge t -> level and pending_duty updated at edge t+1.
REQ-015 Back-to-back sample_valid: each sample processed; pending_duty holds the latest; no samples dropped from the pipeline, earlier ones overwritten in pending_duty.
REQ-016 Counter: cnt (PWM_BITS bits) SHALL increment by 1 per cycle while enable=1, wrapping from 2^PWM_BITS-1 to 0.
REQ-017 Wrap edge: on the edge where cnt goes max->0, the active duty register SHALL load pending_duty (value present before that edge).
REQ-018 A sample captured at or before edge W-2 (W = wrap edge) SHALL take effect in the period starting at W; one captured at W-1 or W takes effect a period later.
REQ-019 sample_tick SHALL be 1 exactly in cycles where enable=1 and cnt = 2^PWM_BITS-1, else 0.
REQ-020 pwm_out SHALL be registered: next value = enable AND (cnt < duty); one-cycle latency from counter.
REQ-021 Duty boundaries: duty=0 -> pwm_out constantly 0; duty=2^PWM_BITS-1 -> high 2^PWM_BITS-1 of 2^PWM_BITS cycles per period.
REQ-022 enable=0: cnt SHALL be forced to 0, sample_tick 0, pwm_out 0 on next edge; duty SHALL load pending_duty every cycle; capture/scale pipeline SHALL keep running.
REQ-023 enable 0->1: counting starts at cnt=0 with duty = latest pending_duty.
REQ-024 Arithmetic: no saturation needed; 0x8000*0xFFFF -> 0x8000; 0x7FFF*0xFFFF -> 0x7FFE; env=0 -> 0.

Reset
REQ-025 reset_n=0 SHALL immediately clear capture regs, level, cnt, sample_tick and pwm_out to 0, and set duty and pending_duty to midscale 2^(PWM_BITS-1).
REQ-026 Reset mid-period or mid-pipeline SHALL discard in-flight samples; after release, first period runs at midscale duty.

Verification
REQ-027 Reset then enable=1, no samples (PWM_BITS=10) -> pwm_out low until first edge, then high 512 / low 512 cycles per 1024-cycle period; sample_tick every 1024 cycles.
REQ-028 sample=0x7FFF, env=0xFFFF -> level=0x7FFE one edge after capture; duty 1023 next period; pwm_out high 1023 of 1024 cycles.
REQ-029 sample=0x8000, env=0xFFFF -> level=0x8000, duty 0, pwm_out constantly 0; then env=0 -> level=0x0000, duty 512.
REQ-030 sample=0x4000, env=0x8000 -> level=0x2000, duty 640; pwm_out high 640 cycles per period.
REQ-031 Sample strobed at W-2 vs at W-1 relative to wrap -> first applied at W, second applied at W+1024.
REQ-032 enable dropped at cnt=300 -> pwm_out 0 and cnt 0 next edge, no sample_tick; reset_n asserted mid-period -> all outputs 0 asynchronously, duty back to 512.

Source files
------------

// File: rtl/env_pwm_dac.sv
// Envelope-scaled sample to offset-binary PWM DAC.
// Capture -> scale -> pending duty, applied at each PWM period wrap.
`timescale 1ns/1ps
module env_pwm_dac #(
    parameter int PWM_BITS = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] sample,
    input  logic        sample_valid,
    input  logic [15:0] env,
    output logic        sample_tick,
    output logic        pwm_out,
    output logic [15:0] level
);

    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
    localparam logic [PWM_BITS-1:0] CNT_ONE = {{(PWM_BITS-1){1'b0}}, 1'b1};
    localparam logic [PWM_BITS-1:0] MID     = {1'b1, {(PWM_BITS-1){1'b0}}};

    logic [15:0]         cap_sample_q, cap_sample_d;
    logic [15:0]         cap_env_q, cap_env_d;
    logic                cap_vld_q, cap_vld_d;
    logic [15:0]         level_q, level_d;
    logic [PWM_BITS-1:0] pend_q, pend_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                pwm_q, pwm_d;

    logic signed [31:0]  prod;
    logic [15:0]         off;
    logic                unused_bits;

    // Product of signed Q1.15 and unsigned Q0.16 always fits in 32 signed bits.
    assign prod = $signed({{16{cap_sample_q[15]}}, cap_sample_q})
                * $signed({16'd0, cap_env_q});
    assign off  = prod[31:16] + 16'h8000;
    assign unused_bits = ^{prod[15:0], off};

    always_comb begin
        cap_vld_d    = sample_valid;
        cap_sample_d = cap_sample_q;
        cap_env_d    = cap_env_q;
        if (sample_valid) begin
            cap_sample_d = sample;
            cap_env_d    = env;
        end

        level_d = level_q;
        pend_d  = pend_q;
        if (cap_vld_q) begin
            level_d = prod[31:16];
            pend_d  = off[15 -: PWM_BITS];
        end

        cnt_d  = '0;
        duty_d = pend_q;
        pwm_d  = 1'b0;
        if (enable) begin
            cnt_d  = cnt_q + CNT_ONE;
            pwm_d  = (cnt_q < duty_q);
            duty_d = (cnt_q == CNT_MAX) ? pend_q : duty_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_sample_q <= '0;
            cap_env_q    <= '0;
            cap_vld_q    <= 1'b0;
            level_q      <= '0;
            pend_q       <= MID;
            cnt_q        <= '0;
            duty_q       <= MID;
            pwm_q        <= 1'b0;
        end else begin
            cap_sample_q <= cap_sample_d;
            cap_env_q    <= cap_env_d;
            cap_vld_q    <= cap_vld_d;
            level_q      <= level_d;
            pend_q       <= pend_d;
            cnt_q        <= cnt_d;
            duty_q       <= duty_d;
            pwm_q        <= pwm_d;
        end
    end

    assign sample_tick = enable && (cnt_q == CNT_MAX);
    assign pwm_out     = pwm_q;
    assign level       = level_q;

endmodule

// File: tb/tb_env_pwm_dac.sv
// Bench for env_pwm_dac: directed cases plus random samples vs a reference model.
`timescale 1ns/1ps
module tb_env_pwm_dac;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] sample = '0;
    logic        sample_valid = 1'b0;
    logic [15:0] env = '0;
    logic        sample_tick;
    logic        pwm_out;
    logic [15:0] level;

    int errors = 0;
    int checks = 0;

    int          m_cnt, m_duty, m_pend;
    logic [15:0] m_level;
    bit          m_pwm;
    bit          m_hc;
    logic [15:0] m_cs, m_ce;

    always #5 clk = ~clk;

    env_pwm_dac #(.PWM_BITS(10)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .sample(sample),
        .sample_valid(sample_valid),
        .env(env),
        .sample_tick(sample_tick),
        .pwm_out(pwm_out),
        .level(level)
    );

    function automatic logic [15:0] scale(logic [15:0] s, logic [15:0] e);
        longint p;
        p = longint'($signed(s)) * longint'({48'd0, e});
        p = p >>> 16;
        return p[15:0];
    endfunction

    function automatic int duty_of(logic [15:0] l);
        logic [15:0] o;
        o = l + 16'h8000;
        return int'(o >> 6);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_duty = 512; m_pend = 512;
        m_level = '0; m_pwm = 0; m_hc = 0;
        m_cs = '0; m_ce = '0;
    endtask

    task automatic step(bit en, bit sv, logic [15:0] s, logic [15:0] e);
        int n_cnt, n_duty;
        bit n_pwm;
        enable = en; sample_valid = sv; sample = s; env = e;
        #1;
        chk("tick", sample_tick, en && (m_cnt == 1023));
        @(posedge clk);
        #1;
        n_pwm = en && (m_cnt < m_duty);
        if (en) begin
            n_cnt  = (m_cnt + 1) % 1024;
            n_duty = (m_cnt == 1023) ? m_pend : m_duty;
        end else begin
            n_cnt  = 0;
            n_duty = m_pend;
        end
        if (m_hc) begin
            m_level = scale(m_cs, m_ce);
            m_pend  = duty_of(m_level);
        end
        m_hc = sv;
        if (sv) begin m_cs = s; m_ce = e; end
        m_cnt = n_cnt; m_duty = n_duty; m_pwm = n_pwm;
        chk("pwm", pwm_out, m_pwm);
        chk("level", level, m_level);
    endtask

    task automatic idle(int n, bit en);
        for (int i = 0; i < n; i++) step(en, 0, 16'h0, 16'h0);
    endtask

    task automatic count_high(int n, int exp, string tag);
        int h;
        h = 0;
        for (int i = 0; i < n; i++) begin
            step(1, 0, 16'h0, 16'h0);
            h += int'(pwm_out);
        end
        chk(tag, h, exp);
    endtask

    task automatic run_until(int v);
        int k;
        k = 0;
        while (m_cnt != v && k < 2048) begin
            step(1, 0, 16'h0, 16'h0);
            k++;
        end
        chk("align", m_cnt, v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_pwm", pwm_out, 0);
        chk("rst_level", level, 0);
        chk("rst_tick", sample_tick, 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();

        idle(2048, 1);
        count_high(1024, 512, "mid_duty");

        step(1, 1, 16'h7FFF, 16'hFFFF);
        step(1, 0, 16'h0, 16'h0);
        chk("lvl_7ffe", level, 16'h7FFE);
        idle(2100, 1);
        count_high(1024, 1023, "max_duty");

        step(1, 1, 16'h8000, 16'hFFFF);
        step(1, 0, 16'h0, 16'h0);
        chk("lvl_8000", level, 16'h8000);
        idle(2100, 1);
        count_high(1024, 0, "zero_duty");

        step(1, 1, 16'h8000, 16'h0000);
        step(1, 0, 16'h0, 16'h0);
        chk("lvl_env0", level, 16'h0000);
        idle(2100, 1);
        count_high(1024, 512, "env0_duty");

        step(1, 1, 16'h4000, 16'h8000);
        step(1, 0, 16'h0, 16'h0);
        chk("lvl_2000", level, 16'h2000);
        idle(2100, 1);
        count_high(1024, 640, "duty_640");

        begin
            bit en;
            en = 1;
            for (int i = 0; i < 6000; i++) begin
                if ($urandom_range(0, 199) == 0) en = !en;
                step(en, $urandom_range(0, 3) == 0,
                     16'($urandom), 16'($urandom));
            end
        end

        idle(5, 1);
        run_until(1021);
        step(1, 1, 16'h7FFF, 16'hFFFF);
        idle(10, 1);
        run_until(1022);
        step(1, 1, 16'h8000, 16'hFFFF);
        count_high(1024, 1023, "late_held");
        count_high(1024, 0, "late_applied");

        step(1, 1, 16'h4000, 16'h8000);
        idle(1100, 1);
        run_until(300);
        step(0, 0, 16'h0, 16'h0);
        chk("dis_pwm", pwm_out, 0);
        chk("dis_tick", sample_tick, 0);
        idle(50, 0);
        idle(1500, 1);

        step(1, 1, 16'h7FFF, 16'hFFFF);
        sample_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_pwm", pwm_out, 0);
        chk("arst_level", level, 0);
        chk("arst_tick", sample_tick, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
        count_high(1024, 512, "post_rst_mid");
        count_high(1024, 512, "post_rst_mid2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
